// File: rtl/pll_cfg_writer.sv
// Avalon-MM initiator that loads a latched counter set into the fractional PLL
// reconfiguration port, starts reconfiguration, polls completion and waits for lock.
module pll_cfg_writer #(
    parameter int unsigned NUM_C        = 3,
    parameter int unsigned LOCK_TIMEOUT = 65535,
    parameter int unsigned SYNC_STAGES  = 2,
    localparam int unsigned CW          = 18,
    localparam int unsigned ADDR_W      = 6,
    localparam int unsigned DATA_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_req,
    input  logic [CW-1:0]         cfg_n,
    input  logic [CW-1:0]         cfg_m,
    input  logic [DATA_W-1:0]     cfg_k,
    input  logic [CW*NUM_C-1:0]   cfg_c,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [ADDR_W-1:0]     mgmt_address,
    output logic                  mgmt_write,
    output logic                  mgmt_read,
    output logic [DATA_W-1:0]     mgmt_writedata,
    input  logic [DATA_W-1:0]     mgmt_readdata,
    input  logic                  mgmt_waitrequest,
    input  logic                  locked
);

    localparam int unsigned CIDX_W = 5;
    localparam int unsigned TMO_W  = $clog2(LOCK_TIMEOUT + 1);

    localparam logic [3:0] S_IDLE      = 4'd0;
    localparam logic [3:0] S_WR_MODE   = 4'd1;
    localparam logic [3:0] S_WR_N      = 4'd2;
    localparam logic [3:0] S_WR_M      = 4'd3;
    localparam logic [3:0] S_WR_K      = 4'd4;
    localparam logic [3:0] S_WR_C      = 4'd5;
    localparam logic [3:0] S_WR_START  = 4'd6;
    localparam logic [3:0] S_POLL      = 4'd7;
    localparam logic [3:0] S_POLL_GAP  = 4'd8;
    localparam logic [3:0] S_WAIT_LOCK = 4'd9;
    localparam logic [3:0] S_DONE      = 4'd10;

    localparam logic [ADDR_W-1:0] A_MODE   = 6'h00;
    localparam logic [ADDR_W-1:0] A_STATUS = 6'h01;
    localparam logic [ADDR_W-1:0] A_START  = 6'h02;
    localparam logic [ADDR_W-1:0] A_N      = 6'h03;
    localparam logic [ADDR_W-1:0] A_M      = 6'h04;
    localparam logic [ADDR_W-1:0] A_C      = 6'h05;
    localparam logic [ADDR_W-1:0] A_K      = 6'h07;

    logic [3:0]            state_q, state_d;
    logic [CIDX_W-1:0]     c_idx_q, c_idx_d;
    logic [TMO_W-1:0]      tmo_q, tmo_d;
    logic [CW-1:0]         n_q, m_q;
    logic [DATA_W-1:0]     k_q;
    logic [CW*NUM_C-1:0]   c_q;
    logic [SYNC_STAGES-1:0] sync_q;
    logic                  lock_seen_q, lock_seen_d;
    logic                  lock_sync;
    logic                  in_wait;
    logic                  timeout_hit;
    logic                  accept;
    logic                  sync_clr;
    logic [CW-1:0]         c_word;
    logic                  busy_d, done_d, error_d, write_d, read_d;
    logic [ADDR_W-1:0]     addr_d;
    logic [DATA_W-1:0]     data_d;
    logic                  unused_rd;

    assign lock_sync = sync_q[SYNC_STAGES-1];
    assign in_wait   = (state_q == S_POLL) || (state_q == S_POLL_GAP) || (state_q == S_WAIT_LOCK);
    assign unused_rd = ^mgmt_readdata[DATA_W-1:1];

    // Next state plus the registered bus/status values for the state being entered
    always_comb begin
        state_d     = state_q;
        c_idx_d     = c_idx_q;
        tmo_d       = tmo_q;
        lock_seen_d = 1'b0;
        error_d     = error;
        accept      = 1'b0;
        timeout_hit = in_wait && (tmo_q == TMO_W'(LOCK_TIMEOUT - 1));
        if (in_wait) begin
            tmo_d = tmo_q + TMO_W'(1);
        end

        case (state_q)
            S_IDLE: begin
                if (cfg_req) begin
                    accept  = 1'b1;
                    error_d = 1'b0;
                    state_d = S_WR_MODE;
                end
            end
            S_WR_MODE:  if (!mgmt_waitrequest) state_d = S_WR_N;
            S_WR_N:     if (!mgmt_waitrequest) state_d = S_WR_M;
            S_WR_M:     if (!mgmt_waitrequest) state_d = S_WR_K;
            S_WR_K: begin
                if (!mgmt_waitrequest) begin
                    state_d = S_WR_C;
                    c_idx_d = '0;
                end
            end
            S_WR_C: begin
                if (!mgmt_waitrequest) begin
                    if (c_idx_q == CIDX_W'(NUM_C - 1)) begin
                        state_d = S_WR_START;
                    end else begin
                        c_idx_d = c_idx_q + CIDX_W'(1);
                    end
                end
            end
            S_WR_START: begin
                if (!mgmt_waitrequest) begin
                    state_d = S_POLL;
                    tmo_d   = '0;
                end
            end
            S_POLL: begin
                if (!mgmt_waitrequest) begin
                    state_d = mgmt_readdata[0] ? S_WAIT_LOCK : S_POLL_GAP;
                end
            end
            S_POLL_GAP: state_d = S_POLL;
            S_WAIT_LOCK: begin
                // two consecutive synchronized highs filter out lock glitches
                lock_seen_d = lock_sync;
                if (lock_sync && lock_seen_q) begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        if (timeout_hit) begin
            state_d = S_IDLE;
            error_d = 1'b1;
        end

        // a stale pre-reconfig lock must not count; restart the synchronizer
        sync_clr = (state_d == S_WAIT_LOCK) && (state_q != S_WAIT_LOCK);

        write_d = 1'b0;
        read_d  = 1'b0;
        addr_d  = '0;
        data_d  = '0;
        c_word  = c_q[int'(c_idx_d) * CW +: CW];
        case (state_d)
            S_WR_MODE: begin
                write_d = 1'b1;
                addr_d  = A_MODE;
                data_d  = DATA_W'(1);
            end
            S_WR_N: begin
                write_d = 1'b1;
                addr_d  = A_N;
                data_d  = {14'b0, n_q};
            end
            S_WR_M: begin
                write_d = 1'b1;
                addr_d  = A_M;
                data_d  = {14'b0, m_q};
            end
            S_WR_K: begin
                write_d = 1'b1;
                addr_d  = A_K;
                data_d  = k_q;
            end
            S_WR_C: begin
                write_d = 1'b1;
                addr_d  = A_C;
                data_d  = {9'b0, c_idx_d, c_word};
            end
            S_WR_START: begin
                write_d = 1'b1;
                addr_d  = A_START;
                data_d  = DATA_W'(1);
            end
            S_POLL: begin
                read_d = 1'b1;
                addr_d = A_STATUS;
            end
            default: begin
                write_d = 1'b0;
            end
        endcase

        busy_d = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d = (state_d == S_DONE);
    end

    // State, captured configuration, synchronizer and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= S_IDLE;
            c_idx_q        <= '0;
            tmo_q          <= '0;
            n_q            <= '0;
            m_q            <= '0;
            k_q            <= '0;
            c_q            <= '0;
            sync_q         <= '0;
            lock_seen_q    <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            error          <= 1'b0;
            mgmt_address   <= '0;
            mgmt_write     <= 1'b0;
            mgmt_read      <= 1'b0;
            mgmt_writedata <= '0;
        end else begin
            state_q        <= state_d;
            c_idx_q        <= c_idx_d;
            tmo_q          <= tmo_d;
            lock_seen_q    <= lock_seen_d;
            busy           <= busy_d;
            done           <= done_d;
            error          <= error_d;
            mgmt_address   <= addr_d;
            mgmt_write     <= write_d;
            mgmt_read      <= read_d;
            mgmt_writedata <= data_d;
            if (accept) begin
                n_q <= cfg_n;
                m_q <= cfg_m;
                k_q <= cfg_k;
                c_q <= cfg_c;
            end
            if (sync_clr) begin
                sync_q <= '0;
            end else begin
                sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
            end
        end
    end

endmodule

// File: tb/tb_pll_cfg_writer.sv
// Directed bench for pll_cfg_writer: bus-order, stall, poll, timeout, busy-ignore
// and mid-transfer reset scenarios against hand-computed expectations.
module tb_pll_cfg_writer;

    localparam int unsigned NUM_C        = 3;
    localparam int unsigned LOCK_TIMEOUT = 100;
    localparam int unsigned SYNC_STAGES  = 2;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b1;
    logic                 cfg_req = 1'b0;
    logic [17:0]          cfg_n = '0;
    logic [17:0]          cfg_m = '0;
    logic [31:0]          cfg_k = '0;
    logic [18*NUM_C-1:0]  cfg_c = '0;
    logic                 busy, done, error;
    logic [5:0]           mgmt_address;
    logic                 mgmt_write, mgmt_read;
    logic [31:0]          mgmt_writedata;
    logic [31:0]          mgmt_readdata;
    logic                 mgmt_waitrequest = 1'b0;
    logic                 locked = 1'b1;

    int wait_mode    = 0;
    int status_zeros = 0;
    int rd_base      = 0;
    int req_cyc      = 0;
    int n_cmp        = 0;
    int n_bad        = 0;
    int cyc          = 0;

    logic [5:0]  wq_addr [$];
    logic [31:0] wq_data [$];
    int          rd_edge [$];
    int          rd_cnt = 0, done_cnt = 0, done_cyc = 0, err_cyc = 0, poll_cyc = 0;
    int          stab_bad = 0, both_bad = 0, done_busy_bad = 0;
    logic        err_busy = 1'b0, prev_err = 1'b0, stalled = 1'b0;
    logic [39:0] held = '0;

    logic [5:0]  exp_addr [8] = '{6'h00, 6'h03, 6'h04, 6'h07, 6'h05, 6'h05, 6'h05, 6'h02};
    logic [31:0] exp_data [8] = '{32'h00000001, 32'h00010000, 32'h00000C0C, 32'h3D70A3D7,
                                  32'h00000303, 32'h00040606, 32'h00080C0C, 32'h00000001};

    pll_cfg_writer #(
        .NUM_C        (NUM_C),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .SYNC_STAGES  (SYNC_STAGES)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .cfg_req          (cfg_req),
        .cfg_n            (cfg_n),
        .cfg_m            (cfg_m),
        .cfg_k            (cfg_k),
        .cfg_c            (cfg_c),
        .busy             (busy),
        .done             (done),
        .error            (error),
        .mgmt_address     (mgmt_address),
        .mgmt_write       (mgmt_write),
        .mgmt_read        (mgmt_read),
        .mgmt_writedata   (mgmt_writedata),
        .mgmt_readdata    (mgmt_readdata),
        .mgmt_waitrequest (mgmt_waitrequest),
        .locked           (locked)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Responder stall pattern, changed just after each active edge
    always @(posedge clk) begin
        #1;
        mgmt_waitrequest <= (wait_mode == 1) ? 1'($urandom_range(0, 1)) : 1'b0;
    end

    // Status bit0 reads 0 for the first status_zeros reads of a scenario
    assign mgmt_readdata = {31'b0, ((rd_cnt - rd_base) > status_zeros)};

    // Bus monitor: whatever is present at the falling edge is what the next rising edge sees
    always @(negedge clk) begin
        if (rst_n) begin
            if (mgmt_write && mgmt_read) both_bad <= both_bad + 1;
            if (stalled && ({mgmt_write, mgmt_read, mgmt_address, mgmt_writedata} != held))
                stab_bad <= stab_bad + 1;
            stalled <= (mgmt_write || mgmt_read) && mgmt_waitrequest;
            held    <= {mgmt_write, mgmt_read, mgmt_address, mgmt_writedata};
            if (mgmt_write && !mgmt_waitrequest) begin
                wq_addr.push_back(mgmt_address);
                wq_data.push_back(mgmt_writedata);
                if (mgmt_address == 6'h02) poll_cyc <= cyc + 1;
            end
            if (mgmt_read && !mgmt_waitrequest) begin
                rd_cnt <= rd_cnt + 1;
                rd_edge.push_back(cyc + 1);
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
                if (busy) done_busy_bad <= done_busy_bad + 1;
            end
            if (error && !prev_err) begin
                err_cyc  <= cyc;
                err_busy <= busy;
            end
            prev_err <= error;
        end else begin
            stalled  <= 1'b0;
            prev_err <= 1'b0;
        end
    end

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_req(input logic [17:0] m);
        @(negedge clk);
        cfg_n   = 18'h10000;
        cfg_m   = m;
        cfg_k   = 32'h3D70A3D7;
        cfg_c   = {18'h00C0C, 18'h00606, 18'h00303};
        cfg_req = 1'b1;
        req_cyc = cyc + 1;
        @(negedge clk);
        cfg_req = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max);
        int base;
        base = done_cnt;
        for (int i = 0; i < max && done_cnt == base; i++) @(negedge clk);
        check_eq({tag, " done_seen"}, 64'(done_cnt != base), 64'd1);
        tick(1);
    endtask

    task automatic check_writes(input string tag, input int base);
        check_eq({tag, " nwrites"}, 64'(wq_addr.size() - base), 64'd8);
        for (int i = 0; i < 8; i++) begin
            if (base + i < wq_addr.size()) begin
                check_eq($sformatf("%s addr%0d", tag, i), 64'(wq_addr[base+i]), 64'(exp_addr[i]));
                check_eq($sformatf("%s data%0d", tag, i), 64'(wq_data[base+i]), 64'(exp_data[i]));
            end
        end
    endtask

    initial begin
        int wb, d0, rb, eb, sb;
        logic found;

        #2 rst_n = 1'b0;
        tick(2);
        check_eq("reset outputs", {busy, done, error, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata},
                 64'd0);
        @(negedge clk) rst_n = 1'b1;
        tick(3);
        check_eq("idle after reset", {busy, mgmt_write, mgmt_read}, 64'd0);

        // Minimum-latency run
        wb = wq_addr.size(); d0 = done_cnt; rd_base = rd_cnt; status_zeros = 0; wait_mode = 0;
        send_req(18'h00C0C);
        check_eq("s1 busy", busy, 1);
        check_eq("s1 error", error, 0);
        wait_done("s1", 100);
        check_eq("s1 done cycle", 64'(done_cyc - req_cyc + 1), 64'd14);
        tick(5);
        check_writes("s1", wb);
        check_eq("s1 reads", 64'(rd_cnt - rd_base), 64'd1);
        check_eq("s1 ndone", 64'(done_cnt - d0), 64'd1);
        check_eq("s1 busy end", busy, 0);

        // Random stalls on every access
        wb = wq_addr.size(); d0 = done_cnt; rd_base = rd_cnt; sb = stab_bad; wait_mode = 1;
        send_req(18'h00C0C);
        wait_done("s2", 400);
        tick(10);
        wait_mode = 0;
        tick(2);
        check_writes("s2", wb);
        check_eq("s2 ndone", 64'(done_cnt - d0), 64'd1);
        check_eq("s2 held while stalled", 64'(stab_bad - sb), 64'd0);

        // Five not-done status reads before completion
        wb = wq_addr.size(); d0 = done_cnt; status_zeros = 5; rd_base = rd_cnt; rb = rd_edge.size();
        send_req(18'h00C0C);
        wait_done("s3", 200);
        tick(3);
        check_eq("s3 reads", 64'(rd_cnt - rd_base), 64'd6);
        for (int k = 1; k < 6; k++) begin
            if (rb + k < rd_edge.size())
                check_eq($sformatf("s3 read gap%0d", k), 64'(rd_edge[rb+k] - rd_edge[rb+k-1]), 64'd2);
        end
        check_eq("s3 ndone", 64'(done_cnt - d0), 64'd1);
        status_zeros = 0;

        // Lock never returns: timeout
        d0 = done_cnt; rd_base = rd_cnt; locked = 1'b0;
        send_req(18'h00C0C);
        for (int i = 0; i < 300 && !error; i++) @(negedge clk);
        check_eq("s4 error", error, 1);
        tick(1);
        check_eq("s4 timeout cycles", 64'(err_cyc - poll_cyc), 64'(LOCK_TIMEOUT));
        check_eq("s4 busy at error", err_busy, 0);
        check_eq("s4 busy", busy, 0);
        check_eq("s4 ndone", 64'(done_cnt - d0), 64'd0);
        locked = 1'b1;
        d0 = done_cnt; rd_base = rd_cnt;
        send_req(18'h00C0C);
        check_eq("s4 error cleared", error, 0);
        wait_done("s4 retry", 100);
        check_eq("s4 retry ndone", 64'(done_cnt - d0), 64'd1);

        // Request while busy with a changed M word is ignored
        wb = wq_addr.size(); d0 = done_cnt; rd_base = rd_cnt;
        send_req(18'h00C0C);
        tick(2);
        cfg_m   = 18'h00A0A;
        cfg_req = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
        wait_done("s5", 100);
        tick(20);
        check_writes("s5", wb);
        check_eq("s5 ndone", 64'(done_cnt - d0), 64'd1);

        // Reset while the K write is on the bus
        rd_base = rd_cnt;
        send_req(18'h00C0C);
        found = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (mgmt_write && mgmt_address == 6'h07) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_eq("s6 at wr_k", found, 1);
        rst_n = 1'b0;
        #1;
        check_eq("s6 reset outputs", {busy, done, error, mgmt_write, mgmt_read, mgmt_address, mgmt_writedata},
                 64'd0);
        @(negedge clk) rst_n = 1'b1;
        wb = wq_addr.size(); d0 = done_cnt;
        tick(8);
        check_eq("s6 idle after release", {busy, mgmt_write, mgmt_read}, 64'd0);
        check_eq("s6 no writes", 64'(wq_addr.size() - wb), 64'd0);
        rd_base = rd_cnt; eb = wq_addr.size();
        send_req(18'h00C0C);
        wait_done("s6 restart", 100);
        tick(3);
        check_writes("s6 restart", eb);
        check_eq("s6 ndone", 64'(done_cnt - d0), 64'd1);

        check_eq("write/read overlap", 64'(both_bad), 64'd0);
        check_eq("done with busy", 64'(done_busy_bad), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
